dispatcher: RTL and testbench

Issue-stage block between the decoder and the reservation station. Renames source operands through an internal 32-entry register alias table (RAT), resolves values from the register file, ROB or the CDBs, and buffers one instruction in a hold slot. It drives the reservation-station assignment interface, stalling the decoder while the station is full.

---
 rtl/dispatcher.sv | 238 +++++++++++++++++++++++
 tb/tb_dispatcher.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatcher.sv
// -----------------------------------------------------------------------------
// dispatcher
//   Issue stage between the decoder and the reservation station. It renames
//   source operands through a 32-entry register alias table (RAT) and resolves
//   each operand from the register file, the ROB or the two CDBs. The resolved
//   instruction sits in a single hold slot until the station takes it.
//
//   Optional feature: define DISPATCH_CDB_BYPASS_EN to forward CDB results
//   combinationally onto out_Qj/out_Vj/out_Qk/out_Vk while the slot waits on
//   that tag. Without it, a CDB hit holds the slot one cycle so the snoop can
//   capture the value first.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ena                      global enable (low freezes all state)
//   in_valid / out_ready     decoder handshake
//   in_op, in_imm, in_pc, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2,
//   in_has_rd, in_rob_tag    decoded instruction and its ROB tag
//   out_rf_raddr*/in_rf_rdata*             register-file reads (combinational)
//   out_rob_qtag*/in_rob_ready*/in_rob_value*  ROB value queries
//   in_alu_cdb_*, in_ls_cdb_*              common data buses
//   in_commit_ena/rd/rob     ROB commit (clears a matching RAT entry)
//   in_flush                 misprediction flush
//   in_rs_has_capacity       reservation station has a free entry
//   out_assignment_ena, out_op, out_imm, out_pc, out_Qj, out_Qk, out_Vj,
//   out_Vk, out_rd_rob, out_has_rd_dest    reservation-station assignment
// -----------------------------------------------------------------------------
module dispatcher #(
   parameter int ROB_W  = 4,
   parameter int DATA_W = 32,
   parameter int OP_W   = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              in_valid,
   output logic              out_ready,
   input  logic [OP_W-1:0]   in_op,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [4:0]        in_rd,
   input  logic              in_use_rs1,
   input  logic              in_use_rs2,
   input  logic              in_has_rd,
   input  logic [ROB_W-1:0]  in_rob_tag,
   output logic [4:0]        out_rf_raddr1,
   output logic [4:0]        out_rf_raddr2,
   input  logic [DATA_W-1:0] in_rf_rdata1,
   input  logic [DATA_W-1:0] in_rf_rdata2,
   output logic [ROB_W-1:0]  out_rob_qtag1,
   output logic [ROB_W-1:0]  out_rob_qtag2,
   input  logic              in_rob_ready1,
   input  logic              in_rob_ready2,
   input  logic [DATA_W-1:0] in_rob_value1,
   input  logic [DATA_W-1:0] in_rob_value2,
   input  logic [ROB_W-1:0]  in_alu_cdb_rob_tag,
   input  logic [DATA_W-1:0] in_alu_cdb_data,
   input  logic [ROB_W-1:0]  in_ls_cdb_rob_tag,
   input  logic [DATA_W-1:0] in_ls_cdb_data,
   input  logic              in_commit_ena,
   input  logic [4:0]        in_commit_rd,
   input  logic [ROB_W-1:0]  in_commit_rob,
   input  logic              in_flush,
   input  logic              in_rs_has_capacity,
   output logic              out_assignment_ena,
   output logic [OP_W-1:0]   out_op,
   output logic [DATA_W-1:0] out_imm,
   output logic [DATA_W-1:0] out_pc,
   output logic [ROB_W-1:0]  out_Qj,
   output logic [ROB_W-1:0]  out_Qk,
   output logic [DATA_W-1:0] out_Vj,
   output logic [DATA_W-1:0] out_Vk,
   output logic [ROB_W-1:0]  out_rd_rob,
   output logic              out_has_rd_dest
);

   localparam logic [ROB_W-1:0] ZERO_ROB = '0;

   typedef struct packed {
      logic              valid;
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] pc;
      logic [ROB_W-1:0]  qj;
      logic [ROB_W-1:0]  qk;
      logic [DATA_W-1:0] vj;
      logic [DATA_W-1:0] vk;
      logic [ROB_W-1:0]  rd_rob;
      logic              has_rd;
   } slot_t;

   slot_t                       slot_q, slot_d;
   logic [31:0][ROB_W-1:0]      rat_q, rat_d;

   logic                        fire, accept, cdb_block;
   logic                        j_alu, j_ls, k_alu, k_ls, j_hit, k_hit;
   logic [DATA_W-1:0]           j_snoop, k_snoop;
   logic [ROB_W+DATA_W-1:0]     res1, res2;

   // {Q, V} for one source operand at accept time.
   function automatic logic [ROB_W+DATA_W-1:0] resolve(
      input logic              use_s,
      input logic [4:0]        idx,
      input logic [ROB_W-1:0]  t,
      input logic [DATA_W-1:0] rf_v,
      input logic              rob_rdy,
      input logic [DATA_W-1:0] rob_v,
      input logic [ROB_W-1:0]  alu_t,
      input logic [DATA_W-1:0] alu_v,
      input logic [ROB_W-1:0]  ls_t,
      input logic [DATA_W-1:0] ls_v);
      if (!use_s || idx == 5'd0) return '0;
      if (t == ZERO_ROB)         return {ZERO_ROB, rf_v};
      if (rob_rdy)               return {ZERO_ROB, rob_v};
      if (t == alu_t)            return {ZERO_ROB, alu_v};
      if (t == ls_t)             return {ZERO_ROB, ls_v};
      return {t, {DATA_W{1'b0}}};
   endfunction

   // Operand queries go out straight from the decoder fields.
   assign out_rf_raddr1 = in_rs1;
   assign out_rf_raddr2 = in_rs2;
   assign out_rob_qtag1 = rat_q[in_rs1];
   assign out_rob_qtag2 = rat_q[in_rs2];

   assign res1 = resolve(in_use_rs1, in_rs1, rat_q[in_rs1], in_rf_rdata1, in_rob_ready1,
                         in_rob_value1, in_alu_cdb_rob_tag, in_alu_cdb_data,
                         in_ls_cdb_rob_tag, in_ls_cdb_data);
   assign res2 = resolve(in_use_rs2, in_rs2, rat_q[in_rs2], in_rf_rdata2, in_rob_ready2,
                         in_rob_value2, in_alu_cdb_rob_tag, in_alu_cdb_data,
                         in_ls_cdb_rob_tag, in_ls_cdb_data);

   // Slot snoop: a pending Q (non-zero) matching either CDB. ALU wins ties.
   assign j_alu   = (slot_q.qj != ZERO_ROB) && (slot_q.qj == in_alu_cdb_rob_tag);
   assign j_ls    = (slot_q.qj != ZERO_ROB) && (slot_q.qj == in_ls_cdb_rob_tag);
   assign k_alu   = (slot_q.qk != ZERO_ROB) && (slot_q.qk == in_alu_cdb_rob_tag);
   assign k_ls    = (slot_q.qk != ZERO_ROB) && (slot_q.qk == in_ls_cdb_rob_tag);
   assign j_hit   = j_alu | j_ls;
   assign k_hit   = k_alu | k_ls;
   assign j_snoop = j_alu ? in_alu_cdb_data : in_ls_cdb_data;
   assign k_snoop = k_alu ? in_alu_cdb_data : in_ls_cdb_data;

`ifdef DISPATCH_CDB_BYPASS_EN
   assign cdb_block = 1'b0;
`else
   // Hold the slot one cycle so the snoop lands before the station sees it.
   assign cdb_block = j_hit | k_hit;
`endif

   assign fire      = ~rst & slot_q.valid & in_rs_has_capacity & ena & ~in_flush & ~cdb_block;
   assign out_ready = ~rst & ~in_flush & ena & (~slot_q.valid | fire);
   assign accept    = in_valid & out_ready;

   always_comb begin
      slot_d = slot_q;
      rat_d  = rat_q;
      if (in_flush) begin
         slot_d = '0;
         rat_d  = '0;
      end else if (ena) begin
         if (slot_q.valid && j_hit) begin
            slot_d.qj = ZERO_ROB;
            slot_d.vj = j_snoop;
         end
         if (slot_q.valid && k_hit) begin
            slot_d.qk = ZERO_ROB;
            slot_d.vk = k_snoop;
         end
         if (fire) slot_d.valid = 1'b0;
         if (accept) begin
            slot_d.valid  = 1'b1;
            slot_d.op     = in_op;
            slot_d.imm    = in_imm;
            slot_d.pc     = in_pc;
            slot_d.qj     = res1[ROB_W+DATA_W-1:DATA_W];
            slot_d.vj     = res1[DATA_W-1:0];
            slot_d.qk     = res2[ROB_W+DATA_W-1:DATA_W];
            slot_d.vk     = res2[DATA_W-1:0];
            slot_d.rd_rob = in_rob_tag;
            slot_d.has_rd = in_has_rd;
         end
         // Commit only clears a mapping nobody has renamed since.
         if (in_commit_ena && in_commit_rd != 5'd0 && rat_q[in_commit_rd] == in_commit_rob)
            rat_d[in_commit_rd] = ZERO_ROB;
         // A same-cycle rename of the same register takes precedence.
         if (accept && in_has_rd && in_rd != 5'd0)
            rat_d[in_rd] = in_rob_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q <= '0;
         rat_q  <= '0;
      end else begin
         slot_q <= slot_d;
         rat_q  <= rat_d;
      end
   end

   always_comb begin
      out_assignment_ena = fire;
      out_op             = slot_q.op;
      out_imm            = slot_q.imm;
      out_pc             = slot_q.pc;
      out_Qj             = slot_q.qj;
      out_Qk             = slot_q.qk;
      out_Vj             = slot_q.vj;
      out_Vk             = slot_q.vk;
      out_rd_rob         = slot_q.rd_rob;
      out_has_rd_dest    = slot_q.has_rd;
`ifdef DISPATCH_CDB_BYPASS_EN
      if (j_hit) begin
         out_Qj = ZERO_ROB;
         out_Vj = j_snoop;
      end
      if (k_hit) begin
         out_Qk = ZERO_ROB;
         out_Vk = k_snoop;
      end
`endif
      // Slot contents may be stale while reset is asserted; present zeros.
      if (rst) begin
         out_op          = '0;
         out_imm         = '0;
         out_pc          = '0;
         out_Qj          = '0;
         out_Qk          = '0;
         out_Vj          = '0;
         out_Vk          = '0;
         out_rd_rob      = '0;
         out_has_rd_dest = 1'b0;
      end
   end

endmodule

// File: tb/tb_dispatcher.sv
module tb_dispatcher;
   localparam int ROB_W = 4, DATA_W = 32, OP_W = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, ena, in_valid, out_ready;
   logic [OP_W-1:0] in_op, out_op;
   logic [DATA_W-1:0] in_imm, in_pc, out_imm, out_pc;
   logic [4:0] in_rs1, in_rs2, in_rd, out_rf_raddr1, out_rf_raddr2, in_commit_rd;
   logic in_use_rs1, in_use_rs2, in_has_rd;
   logic [ROB_W-1:0] in_rob_tag, out_rob_qtag1, out_rob_qtag2;
   logic [DATA_W-1:0] in_rf_rdata1, in_rf_rdata2, in_rob_value1, in_rob_value2;
   logic in_rob_ready1, in_rob_ready2;
   logic [ROB_W-1:0] in_alu_cdb_rob_tag, in_ls_cdb_rob_tag, in_commit_rob;
   logic [DATA_W-1:0] in_alu_cdb_data, in_ls_cdb_data;
   logic in_commit_ena, in_flush, in_rs_has_capacity, out_assignment_ena;
   logic [ROB_W-1:0] out_Qj, out_Qk, out_rd_rob;
   logic [DATA_W-1:0] out_Vj, out_Vk;
   logic out_has_rd_dest;

   // Register file and ROB models answering the combinational queries.
   logic [DATA_W-1:0] rf [32];
   logic [DATA_W-1:0] rob_val [16];
   logic              rob_rdy [16];
   assign in_rf_rdata1  = rf[out_rf_raddr1];
   assign in_rf_rdata2  = rf[out_rf_raddr2];
   assign in_rob_ready1 = rob_rdy[out_rob_qtag1];
   assign in_rob_ready2 = rob_rdy[out_rob_qtag2];
   assign in_rob_value1 = rob_val[out_rob_qtag1];
   assign in_rob_value2 = rob_val[out_rob_qtag2];

   dispatcher #(.ROB_W(ROB_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
      .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .out_ready(out_ready),
      .in_op(in_op), .in_imm(in_imm), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_rd(in_rd), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
      .in_has_rd(in_has_rd), .in_rob_tag(in_rob_tag),
      .out_rf_raddr1(out_rf_raddr1), .out_rf_raddr2(out_rf_raddr2),
      .in_rf_rdata1(in_rf_rdata1), .in_rf_rdata2(in_rf_rdata2),
      .out_rob_qtag1(out_rob_qtag1), .out_rob_qtag2(out_rob_qtag2),
      .in_rob_ready1(in_rob_ready1), .in_rob_ready2(in_rob_ready2),
      .in_rob_value1(in_rob_value1), .in_rob_value2(in_rob_value2),
      .in_alu_cdb_rob_tag(in_alu_cdb_rob_tag), .in_alu_cdb_data(in_alu_cdb_data),
      .in_ls_cdb_rob_tag(in_ls_cdb_rob_tag), .in_ls_cdb_data(in_ls_cdb_data),
      .in_commit_ena(in_commit_ena), .in_commit_rd(in_commit_rd),
      .in_commit_rob(in_commit_rob), .in_flush(in_flush),
      .in_rs_has_capacity(in_rs_has_capacity), .out_assignment_ena(out_assignment_ena),
      .out_op(out_op), .out_imm(out_imm), .out_pc(out_pc), .out_Qj(out_Qj),
      .out_Qk(out_Qk), .out_Vj(out_Vj), .out_Vk(out_Vk), .out_rd_rob(out_rd_rob),
      .out_has_rd_dest(out_has_rd_dest));

   typedef struct {
      logic [OP_W-1:0]   op;
      logic [ROB_W-1:0]  qj, qk;
      logic [DATA_W-1:0] vj, vk;
      logic [ROB_W-1:0]  rd_rob;
      logic              has_rd;
   } exp_t;

   exp_t sb [$];
   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push(input logic [OP_W-1:0] op, input logic [ROB_W-1:0] qj, qk,
                       input logic [DATA_W-1:0] vj, vk, input logic [ROB_W-1:0] rdr,
                       input logic hr);
      exp_t e;
      e.op = op; e.qj = qj; e.qk = qk; e.vj = vj; e.vk = vk; e.rd_rob = rdr; e.has_rd = hr;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic [OP_W-1:0] op, input logic [4:0] rs1, rs2, rd,
                        input logic u1, u2, hr, input logic [ROB_W-1:0] tag);
      in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
      in_use_rs1 = u1; in_use_rs2 = u2; in_has_rd = hr; in_rob_tag = tag;
      in_imm = 32'h100 + 32'(op); in_pc = 32'h4000 + 32'(op);
   endtask

   // Scoreboard consumer: every assignment strobe pops one expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (out_assignment_ena === 1'b1) begin
         if (sb.size() == 0) chk("sb_underflow", 1, 0);
         else begin
            e = sb.pop_front();
            chk("op",  32'(out_op), 32'(e.op));
            chk("imm", out_imm, 32'h100 + 32'(e.op));
            chk("pc",  out_pc,  32'h4000 + 32'(e.op));
            chk("Qj",  32'(out_Qj), 32'(e.qj));
            chk("Qk",  32'(out_Qk), 32'(e.qk));
            chk("Vj",  out_Vj, e.vj);
            chk("Vk",  out_Vk, e.vk);
            chk("rd_rob", 32'(out_rd_rob), 32'(e.rd_rob));
            chk("has_rd", 32'(out_has_rd_dest), 32'(e.has_rd));
         end
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + 32'(i);
      for (int i = 0; i < 16; i++) begin rob_val[i] = 32'hdead0000 + 32'(i); rob_rdy[i] = 1'b0; end
      rf[5] = 32'h11; rf[7] = 32'h77;
      rst = 1'b1; ena = 1'b1; in_valid = 1'b0; in_op = '0; in_imm = '0; in_pc = '0;
      in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_use_rs1 = 0; in_use_rs2 = 0; in_has_rd = 0;
      in_rob_tag = '0; in_alu_cdb_rob_tag = '0; in_alu_cdb_data = '0;
      in_ls_cdb_rob_tag = '0; in_ls_cdb_data = '0; in_commit_ena = 0; in_commit_rd = '0;
      in_commit_rob = '0; in_flush = 0; in_rs_has_capacity = 1'b1;

      // Reset
      tick();
      @(negedge clk);
      chk("rst_ready", 32'(out_ready), 0);
      chk("rst_asg", 32'(out_assignment_ena), 0);
      chk("rst_Vj", out_Vj, 0);
      in_rs1 = 5'd3;
      @(negedge clk);
      chk("rst_rat3", 32'(out_rob_qtag1), 0);
      tick();
      rst = 1'b0;

      // add x3,x5,x5 (tag 2)
      issue(6'd1, 5'd5, 5'd5, 5'd3, 1, 1, 1, 4'd2);
      push(6'd1, 0, 0, 32'h11, 32'h11, 4'd2, 1);
      @(negedge clk);
      chk("ready_empty", 32'(out_ready), 1);
      tick();

      // add x4,x3,x0 (tag 3), dependent on tag 2
      issue(6'd2, 5'd3, 5'd0, 5'd4, 1, 1, 1, 4'd3);
      push(6'd2, 0, 0, 32'h99, 0, 4'd3, 1);
      @(negedge clk);
      chk("fire1", 32'(out_assignment_ena), 1);
      chk("rat3_is2", 32'(out_rob_qtag1), 2);
      chk("ready_during_fire", 32'(out_ready), 1);
      tick();

      // Station full for three cycles; CDB for tag 2 arrives in the middle.
      in_valid = 1'b0; in_rs_has_capacity = 1'b0;
      @(negedge clk);
      chk("dep_Qj", 32'(out_Qj), 2);
      chk("dep_Qk", 32'(out_Qk), 0);
      chk("full_ready1", 32'(out_ready), 0);
      chk("full_asg1", 32'(out_assignment_ena), 0);
      tick();
      in_alu_cdb_rob_tag = 4'd2; in_alu_cdb_data = 32'h99;
      @(negedge clk);
      chk("full_ready2", 32'(out_ready), 0);
      tick();
      in_alu_cdb_rob_tag = '0; in_alu_cdb_data = '0;
      @(negedge clk);
      chk("snoop_Qj", 32'(out_Qj), 0);
      chk("snoop_Vj", out_Vj, 32'h99);
      chk("full_ready3", 32'(out_ready), 0);
      tick();

      // Capacity returns; same cycle: accept rd=x3 tag5 racing commit (x3,2).
      in_rs_has_capacity = 1'b1;
      issue(6'd3, 5'd0, 5'd0, 5'd3, 0, 0, 1, 4'd5);
      push(6'd3, 0, 0, 0, 0, 4'd5, 1);
      in_commit_ena = 1'b1; in_commit_rd = 5'd3; in_commit_rob = 4'd2;
      @(negedge clk);
      chk("fire_after_full", 32'(out_assignment_ena), 1);
      chk("ready_after_full", 32'(out_ready), 1);
      tick();
      in_valid = 1'b0; in_commit_ena = 1'b0; in_rs1 = 5'd3;
      @(negedge clk);
      chk("race_rat3", 32'(out_rob_qtag1), 5);
      in_commit_ena = 1'b1; in_commit_rd = 5'd3; in_commit_rob = 4'd2;
      tick();
      in_commit_ena = 1'b0;
      @(negedge clk);
      chk("stale_commit", 32'(out_rob_qtag1), 5);
      in_commit_ena = 1'b1; in_commit_rd = 5'd3; in_commit_rob = 4'd5;
      tick();
      in_commit_ena = 1'b0;
      @(negedge clk);
      chk("match_commit", 32'(out_rob_qtag1), 0);

      // Flush with a valid slot and RAT[7]=4.
      in_rs_has_capacity = 1'b0;
      issue(6'd4, 5'd0, 5'd0, 5'd7, 0, 0, 1, 4'd4);
      tick();
      in_valid = 1'b0; in_rs1 = 5'd7; in_flush = 1'b1;
      @(negedge clk);
      chk("pre_flush_rat7", 32'(out_rob_qtag1), 4);
      chk("flush_ready", 32'(out_ready), 0);
      chk("flush_asg", 32'(out_assignment_ena), 0);
      tick();
      in_flush = 1'b0; in_rs_has_capacity = 1'b1;
      @(negedge clk);
      chk("post_flush_asg", 32'(out_assignment_ena), 0);
      chk("post_flush_rat7", 32'(out_rob_qtag1), 0);
      issue(6'd5, 5'd7, 5'd0, 5'd0, 1, 0, 0, 4'd6);
      push(6'd5, 0, 0, 32'h77, 0, 4'd6, 0);
      tick();

      // ROB-ready and CDB-at-accept resolution (ALU wins over LS).
      issue(6'd6, 5'd0, 5'd0, 5'd8, 0, 0, 1, 4'd7);
      push(6'd6, 0, 0, 0, 0, 4'd7, 1);
      tick();
      rob_rdy[7] = 1'b1; rob_val[7] = 32'habc;
      issue(6'd7, 5'd8, 5'd0, 5'd0, 1, 0, 0, 4'd8);
      push(6'd7, 0, 0, 32'habc, 0, 4'd8, 0);
      tick();
      rob_rdy[7] = 1'b0;
      in_alu_cdb_rob_tag = 4'd7; in_alu_cdb_data = 32'h555;
      in_ls_cdb_rob_tag = 4'd7; in_ls_cdb_data = 32'h666;
      issue(6'd8, 5'd8, 5'd8, 5'd0, 1, 1, 0, 4'd9);
      push(6'd8, 0, 0, 32'h555, 32'h555, 4'd9, 0);
      tick();
      in_valid = 1'b0;
      in_alu_cdb_rob_tag = '0; in_ls_cdb_rob_tag = '0;
      tick();

      // Slot waiting on tag 6 meets the LS CDB while the station has room.
      issue(6'd9, 5'd0, 5'd0, 5'd9, 0, 0, 1, 4'd6);
      push(6'd9, 0, 0, 0, 0, 4'd6, 1);
      tick();
      issue(6'd10, 5'd9, 5'd0, 5'd0, 1, 0, 0, 4'd10);
      push(6'd10, 0, 0, 32'h1234, 0, 4'd10, 0);
      tick();
      in_valid = 1'b0; in_ls_cdb_rob_tag = 4'd6; in_ls_cdb_data = 32'h1234;
      @(negedge clk);
`ifdef DISPATCH_CDB_BYPASS_EN
      chk("byp_fire_now", 32'(out_assignment_ena), 1);
`else
      chk("byp_fire_held", 32'(out_assignment_ena), 0);
`endif
      tick();
      in_ls_cdb_rob_tag = '0; in_ls_cdb_data = '0;
      @(negedge clk);
`ifdef DISPATCH_CDB_BYPASS_EN
      chk("byp_no_refire", 32'(out_assignment_ena), 0);
`else
      chk("byp_fire_late", 32'(out_assignment_ena), 1);
`endif
      tick();

      // Enable low: no accept, no state change.
      ena = 1'b0;
      issue(6'd11, 5'd0, 5'd0, 5'd0, 0, 0, 0, 4'd11);
      @(negedge clk);
      chk("ena_ready", 32'(out_ready), 0);
      tick();
      ena = 1'b1;
      @(negedge clk);
      chk("ena_no_load", 32'(out_assignment_ena), 0);
      chk("ena_ready_back", 32'(out_ready), 1);
      push(6'd11, 0, 0, 0, 0, 4'd11, 0);
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      chk("sb_empty", 32'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
